// File: rtl/regfifo_param.sv
`default_nettype none
// ============================================================================
// Module      : regfifo_param
// Description : Register-based shift FIFO with first-word fall-through output.
//               Entry 0 is always the head, valid bits are packed from bit 0,
//               and reads shift the whole array down by one slot.
//               Optional sticky overflow/underflow flags are built only when
//               the macro REGFIFO_ERR_EN is defined; otherwise both are tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module regfifo_param #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 10,
    parameter int AFULL_TH   = DEPTH - 2,
    parameter int AEMPTY_TH  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_WIDTH-1:0]  data_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [CNT_WIDTH-1:0] c_afull_th  = CNT_WIDTH'(AFULL_TH);
    localparam logic [CNT_WIDTH-1:0] c_aempty_th = CNT_WIDTH'(AEMPTY_TH);
    localparam logic [CNT_WIDTH-1:0] c_one       = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_data      [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [CNT_WIDTH-1:0]  r_count;

    logic [DATA_WIDTH-1:0] w_data_nxt  [DEPTH];
    logic [DEPTH-1:0]      w_valid_nxt;
    logic [CNT_WIDTH-1:0]  w_count_nxt;
    logic [CNT_WIDTH-1:0]  w_wr_idx;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // Status comes from the registered bitmap only, never from the request inputs.
    assign w_full   = r_valid[DEPTH-1];
    assign w_empty  = ~r_valid[0];
    // A write into a full FIFO is still accepted when a read frees a slot the same cycle.
    assign w_wr_acc = wr_en & (~w_full | rd_en);
    assign w_rd_acc = rd_en & ~w_empty;
    // New data lands in the first free slot after any shift caused by the read.
    assign w_wr_idx = w_rd_acc ? (r_count - c_one) : r_count;

    // Next-state: flush, else shift on read then insert on write.
    always_comb begin
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_count_nxt = r_count;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_data_nxt[i] = '0;
            end
            w_valid_nxt = '0;
            w_count_nxt = '0;
        end else begin
            if (w_rd_acc) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    w_data_nxt[i] = r_data[i+1];
                end
                // Vacated top slot is zeroed so an empty head always reads as 0.
                w_data_nxt[DEPTH-1] = '0;
                w_valid_nxt         = {1'b0, r_valid[DEPTH-1:1]};
            end
            if (w_wr_acc) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CNT_WIDTH'(i) == w_wr_idx) begin
                        w_data_nxt[i]  = din;
                        w_valid_nxt[i] = 1'b1;
                    end
                end
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   w_count_nxt = r_count + c_one;
                2'b01:   w_count_nxt = r_count - c_one;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Storage, bitmap and count registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
        end
    end

`ifdef REGFIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags, cleared only by reset or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= r_overflow  | (wr_en & w_full & ~rd_en);
            r_underflow <= r_underflow | (rd_en & w_empty);
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign dout         = r_data[0];
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_afull_th);
    assign almost_empty = (r_count <= c_aempty_th);
    assign data_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_regfifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfifo_param
// Description : Self-checking bench for regfifo_param. A queue-based model
//               tracks the FIFO contents; directed steps and random traffic
//               are compared against it after every clock edge. A second,
//               small instance checks asynchronous reset without a clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfifo_param;

    localparam int DW = 64;
    localparam int DP = 8;
    localparam int CW = 10;
    localparam int AF = DP - 2;
    localparam int AE = 1;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] data_count;
    logic          overflow;
    logic          underflow;

    logic          rst2_n;
    logic          clr2;
    logic          wr2;
    logic          rd2;
    logic [31:0]   din2;
    logic [31:0]   dout2;
    logic          full2;
    logic          empty2;
    logic          af2;
    logic          ae2;
    logic [2:0]    cnt2;
    logic          ovf2;
    logic          udf2;

    int nerr = 0;
    int ntot = 0;

    // Reference model state
    logic [DW-1:0] mq [$];
    logic          m_ovf;
    logic          m_udf;

    regfifo_param u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .data_count   (data_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    regfifo_param #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .CNT_WIDTH  (3)
    ) u_small (
        .clk          (clk),
        .rst_n        (rst2_n),
        .clr          (clr2),
        .wr_en        (wr2),
        .din          (din2),
        .rd_en        (rd2),
        .dout         (dout2),
        .full         (full2),
        .empty        (empty2),
        .almost_full  (af2),
        .almost_empty (ae2),
        .data_count   (cnt2),
        .overflow     (ovf2),
        .underflow    (udf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        ntot++;
        assert (act === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Compare every main-instance output against the model.
    task automatic check_all(input string tag);
        logic          e_ovf;
        logic          e_udf;
        logic [DW-1:0] e_dout;
        int            n;
        n      = mq.size();
        e_dout = (n > 0) ? mq[0] : '0;
`ifdef REGFIFO_ERR_EN
        e_ovf = m_ovf;
        e_udf = m_udf;
`else
        e_ovf = 1'b0;
        e_udf = 1'b0;
`endif
        chk({tag, ".dout"},  dout, e_dout);
        chk({tag, ".count"}, DW'(data_count), DW'(n));
        chk({tag, ".full"},  DW'(full), DW'(n == DP));
        chk({tag, ".empty"}, DW'(empty), DW'(n == 0));
        chk({tag, ".afull"}, DW'(almost_full), DW'(n >= AF));
        chk({tag, ".aempty"}, DW'(almost_empty), DW'(n <= AE));
        chk({tag, ".ovf"},   DW'(overflow), DW'(e_ovf));
        chk({tag, ".udf"},   DW'(underflow), DW'(e_udf));
    endtask

    // Model of one clock edge, written from the FIFO's externally visible rules.
    task automatic model_edge(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
        int n;
        n = mq.size();
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && n == DP && !r) m_ovf = 1'b1;
            if (r && n == 0)        m_udf = 1'b1;
            if (r && n > 0)         void'(mq.pop_front());
            if (w && (n < DP || r)) mq.push_back(d);
        end
    endtask

    task automatic step(input string tag, input logic w, input logic r, input logic c, input logic [DW-1:0] d);
        wr_en = w;
        rd_en = r;
        clr   = c;
        din   = d;
        @(posedge clk);
        model_edge(w, r, c, d);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
        din   = '0;
        check_all(tag);
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        clr2 = 1'b0; wr2 = 1'b0; rd2 = 1'b0; din2 = '0;
        m_ovf = 1'b0; m_udf = 1'b0;

        // Outputs while reset is held
        repeat (2) @(posedge clk);
        #1;
        check_all("in_reset");
        rst_n = 1'b1; rst2_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset");

        // Fill with 0x11..0x88
        for (int i = 1; i <= 8; i++) begin
            step("fill", 1'b1, 1'b0, 1'b0, DW'(i * 8'h11));
        end

        // Write while full is dropped
        step("wr_full", 1'b1, 1'b0, 1'b0, 64'h99);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            step("drain", 1'b0, 1'b1, 1'b0, '0);
        end

        // Simultaneous read/write when empty: write only
        step("rw_empty", 1'b1, 1'b1, 1'b0, 64'hAA);
        step("pop_aa", 1'b0, 1'b1, 1'b0, '0);

        // Count 3, simultaneous read/write keeps count and appends
        step("wr_a", 1'b1, 1'b0, 1'b0, 64'hA);
        step("wr_b", 1'b1, 1'b0, 1'b0, 64'hB);
        step("wr_c", 1'b1, 1'b0, 1'b0, 64'hC);
        step("rw_mid", 1'b1, 1'b1, 1'b0, 64'hD);
        for (int i = 0; i < 3; i++) begin
            step("rd_bcd", 1'b0, 1'b1, 1'b0, '0);
        end

        // Read while empty
        step("rd_empty", 1'b0, 1'b1, 1'b0, '0);

        // Full with simultaneous read/write writes into the top slot
        for (int i = 0; i < 8; i++) begin
            step("refill", 1'b1, 1'b0, 1'b0, rnd64());
        end
        step("rw_full", 1'b1, 1'b1, 1'b0, 64'hF00D);
        step("wr_full2", 1'b1, 1'b0, 1'b0, 64'hBAD);
        for (int i = 0; i < 3; i++) begin
            step("part_drain", 1'b0, 1'b1, 1'b0, '0);
        end

        // Count 5, flush with a concurrent write
        step("clr_wr", 1'b1, 1'b0, 1'b1, 64'h5555);
        step("after_clr", 1'b0, 1'b0, 1'b0, '0);

        // Random traffic: fill-biased, then drain-biased
        for (int i = 0; i < 400; i++) begin
            logic w;
            logic r;
            logic c;
            if (i < 200) begin
                w = ($urandom_range(0, 99) < 75);
                r = ($urandom_range(0, 99) < 30);
            end else begin
                w = ($urandom_range(0, 99) < 30);
                r = ($urandom_range(0, 99) < 75);
            end
            c = ($urandom_range(0, 99) < 2);
            step("rand", w, r, c, rnd64());
        end

        // Mid-operation asynchronous reset on the main instance
        for (int i = 0; i < 4; i++) begin
            step("pre_rst", 1'b1, 1'b0, 1'b0, rnd64());
        end
        #2;
        rst_n = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("first_after_rst", 1'b1, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0);

        // Small instance: two writes, then asynchronous reset between edges
        wr2  = 1'b1;
        din2 = 32'hCAFE_0001;
        @(posedge clk);
        #1;
        din2 = 32'hCAFE_0002;
        @(posedge clk);
        #1;
        wr2  = 1'b0;
        din2 = '0;
        chk("small.count2", DW'(cnt2), DW'(2));
        chk("small.dout2", DW'(dout2), DW'(32'hCAFE_0001));
        #2;
        rst2_n = 1'b0;
        #1;
        chk("small_rst.dout",   DW'(dout2), '0);
        chk("small_rst.empty",  DW'(empty2), DW'(1));
        chk("small_rst.full",   DW'(full2), DW'(0));
        chk("small_rst.aempty", DW'(ae2), DW'(1));
        chk("small_rst.afull",  DW'(af2), DW'(0));
        chk("small_rst.count",  DW'(cnt2), DW'(0));
        chk("small_rst.ovf",    DW'(ovf2), DW'(0));
        chk("small_rst.udf",    DW'(udf2), DW'(0));

        $display("Result: errors=%0d of %0d checks", nerr, ntot);
        $finish;
    end

endmodule
`default_nettype wire
